// File: rtl/dmem_dbus_responder.sv
// Data-memory responder on the data bus.
// Word-organised RAM with byte-lane stores. A programmable number of wait states precede a
// one-cycle ack that carries the read data.
// Optional feature: define DMEM_OUT_REG_EN to add one output register stage on r_data/ack.
// In that build the FSM adds a DRAIN state so that the request is not re-accepted.

typedef struct packed {
  logic [31:0] addr;
  logic [31:0] w_data;
  logic [3:0]  sel_byte;
  logic        req;
  logic        w_en;
} type_dbus2peri_s;

typedef struct packed {
  logic [31:0] r_data;
  logic        ack;
} type_peri2dbus_s;

module dmem_dbus_responder #(
  parameter int unsigned DEPTH       = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  type_dbus2peri_s dbus2peri_i,
  input  logic            dmem_sel_i,
  output type_peri2dbus_s mem2dbus_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [3:0] WaitLoad = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {StIdle, StWait, StAck, StDrain} state_e;

  state_e          state_q;
  logic [3:0]      cnt_q;
  logic [AW-1:0]   idx_q;
  logic [31:0]     wdata_q;
  logic [3:0]      be_q;
  logic            wen_q;
  logic            ack_q;
  logic [31:0]     rdata_q;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   acc_idx;
  logic            accept;
  logic            unused_addr_bits;

  // Upper address bits alias and addr[1:0] never selects a word.
  assign acc_idx          = dbus2peri_i.addr[AW+1:2];
  assign accept           = dmem_sel_i & dbus2peri_i.req;
  assign unused_addr_bits = ^{dbus2peri_i.addr[31:AW+2], dbus2peri_i.addr[1:0]};

  // Access FSM; ack and read data are registered on entry to ACK.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      wen_q   <= 1'b0;
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      ack_q   <= 1'b0;
      rdata_q <= 32'd0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            idx_q   <= acc_idx;
            wdata_q <= dbus2peri_i.w_data;
            be_q    <= dbus2peri_i.sel_byte;
            wen_q   <= dbus2peri_i.w_en;
            cnt_q   <= WaitLoad;
            if (WAIT_STATES > 0) begin
              state_q <= StWait;
            end else begin
              state_q <= StAck;
              ack_q   <= 1'b1;
              rdata_q <= dbus2peri_i.w_en ? 32'd0 : mem[acc_idx];
            end
          end
        end
        StWait: begin
          if (cnt_q == 4'd0) begin
            state_q <= StAck;
            ack_q   <= 1'b1;
            rdata_q <= wen_q ? 32'd0 : mem[idx_q];
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StAck: begin
`ifdef DMEM_OUT_REG_EN
          // Output stage shows ack next cycle; hold off re-accept until it has gone.
          state_q <= StDrain;
`else
          state_q <= StIdle;
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Store commits at the end of the ACK cycle; a reset before then leaves the RAM untouched.
  always_ff @(posedge clk) begin
    if (state_q == StAck && wen_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

`ifdef DMEM_OUT_REG_EN
  logic        ack_out_q;
  logic [31:0] rdata_out_q;

  // Extra output register stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_out_q   <= 1'b0;
      rdata_out_q <= 32'd0;
    end else begin
      ack_out_q   <= ack_q;
      rdata_out_q <= rdata_q;
    end
  end

  // Drive the bus response from the output stage.
  always_comb begin
    mem2dbus_o        = '0;
    mem2dbus_o.ack    = ack_out_q;
    mem2dbus_o.r_data = rdata_out_q;
  end
`else
  // Drive the bus response straight from the FSM registers.
  always_comb begin
    mem2dbus_o        = '0;
    mem2dbus_o.ack    = ack_q;
    mem2dbus_o.r_data = rdata_q;
  end
`endif

endmodule
